fetch_stream: RTL and testbench

- Next-generation fetch stage. Replaces the free-running PC+4 counter with a stream engine.
- Issues instruction-memory requests through a valid/ready handshake and holds up to FQ_DEPTH in-flight and returned instructions in a reserve-then-fill queue.
- Presents {pc, insn} to decode with valid/ready.
- Supports a redirect from execute for branches and jumps, which flushes everything younger.
- Sits between the PC source/imem port and decode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_stream.sv | 102 ++++++++++
 tb/tb_fetch_stream.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stream.
// Queue entries carry the codebase-wide address/instruction widths below.
package fetch_pkg;

    localparam int FETCH_AWIDTH = 32;
    localparam int FETCH_DWIDTH = 32;
    localparam int INSN_BYTES   = 4;
    localparam logic [FETCH_AWIDTH-1:0] PC_ALIGN_MASK = ~FETCH_AWIDTH'(INSN_BYTES - 1);

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
        logic                    filled;
    } fetch_entry_t;

    function automatic logic [FETCH_AWIDTH-1:0] align_pc(input logic [FETCH_AWIDTH-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular reserve-then-fill queue: entries are reserved in request order,
// filled in response order and popped from the head once filled.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 4,
    localparam int PW = $clog2(FQ_DEPTH),
    localparam int CW = $clog2(FQ_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_reserve,
    input  logic [FETCH_AWIDTH-1:0] i_res_pc,
    input  logic                    i_fill,
    input  logic [FETCH_DWIDTH-1:0] i_fill_insn,
    input  logic                    i_pop,
    output fetch_entry_t            o_head,
    output logic [CW-1:0]           o_count
);

    logic [FETCH_AWIDTH-1:0] r_pc   [FQ_DEPTH];
    logic [FETCH_DWIDTH-1:0] r_insn [FQ_DEPTH];
    logic [FQ_DEPTH-1:0]     r_filled;
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [PW-1:0]           r_fill;
    logic [CW-1:0]           r_count;

    // Pointers wrap naturally because FQ_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_fill   <= '0;
            r_count  <= '0;
            r_filled <= '0;
        end else begin
            if (i_reserve) begin
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PW'(1);
            end
            if (i_fill) begin
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PW'(1);
            end
            if (i_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(i_reserve) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reserve)
            r_pc[r_tail] <= i_res_pc;
        if (i_fill)
            r_insn[r_fill] <= i_fill_insn;
    end

    always_comb begin
        o_head        = '0;
        o_head.pc     = r_pc[r_head];
        o_head.insn   = r_insn[r_head];
        o_head.filled = r_filled[r_head];
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_stream.sv
// Fetch stage stream engine: issues imem requests, queues returned
// instructions for decode and handles redirects by flushing younger work.
module fetch_stream
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int                FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              resp_valid_i,
    input  logic [DWIDTH-1:0] resp_insn_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam int CW  = $clog2(FQ_DEPTH) + 1;
    localparam int DCW = CW + 1;

    logic [AWIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]     r_outstanding;
    logic [DCW-1:0]    r_drop_cnt;

    fetch_entry_t      w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_fire;
    logic              w_drop;
    logic              w_fill;
    logic              w_pop;

    // Issue decision uses registered count only, so decode ready never reaches req_valid_o.
    assign w_full      = (w_count == CW'(FQ_DEPTH));
    assign req_valid_o = !rst && !redirect_i && !w_full;
    assign req_addr_o  = r_fetch_pc;
    assign w_fire      = req_valid_o && req_ready_i;

    // Responses to requests issued before a redirect are consumed silently.
    assign w_drop = resp_valid_i && (r_drop_cnt != '0);
    assign w_fill = resp_valid_i && !w_drop && !redirect_i;

    assign valid_o = !rst && !redirect_i && w_head.filled;
    assign w_pop   = valid_o && ready_i;
    assign pc_o    = valid_o ? AWIDTH'(w_head.pc)   : '0;
    assign insn_o  = valid_o ? DWIDTH'(w_head.insn) : '0;

    // r_outstanding counts live requests that will fill the queue; r_drop_cnt counts stale ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= BASEADDR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_i) begin
            r_fetch_pc    <= AWIDTH'(align_pc(FETCH_AWIDTH'(redirect_pc_i)));
            r_drop_cnt    <= r_drop_cnt + DCW'(r_outstanding) - DCW'(resp_valid_i);
            r_outstanding <= '0;
        end else begin
            if (w_fire)
                r_fetch_pc <= r_fetch_pc + AWIDTH'(INSN_BYTES);
            if (w_drop)
                r_drop_cnt <= r_drop_cnt - DCW'(1);
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_fill);
        end
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_i),
        .i_reserve   (w_fire),
        .i_res_pc    (FETCH_AWIDTH'(r_fetch_pc)),
        .i_fill      (w_fill),
        .i_fill_insn (FETCH_DWIDTH'(resp_insn_i)),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    property p_count_bounds;
        @(posedge clk) disable iff (rst)
            (r_outstanding <= w_count) && (w_count <= CW'(FQ_DEPTH));
    endproperty
    assert property (p_count_bounds);

    property p_inflight_bound;
        @(posedge clk) disable iff (rst)
            (int'(r_drop_cnt) + int'(r_outstanding)) <= 2 * FQ_DEPTH;
    endproperty
    assert property (p_inflight_bound);

endmodule

// File: tb/tb_fetch_stream.sv
// Bench for fetch_stream: imem latency model, PC reference model and
// scoreboard of expected head PCs, plus directed corner-case sequences.
module tb_fetch_stream;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          FQ   = 4;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_o, req_ready_i;
    logic [AW-1:0] req_addr_o;
    logic          resp_valid_i;
    logic [DW-1:0] resp_insn_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          valid_o, ready_i;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] insn_o;

    always #5 clk = ~clk;

    fetch_stream #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .BASEADDR (BASE),
        .FQ_DEPTH (FQ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .resp_valid_i  (resp_valid_i),
        .resp_insn_i   (resp_insn_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .insn_o        (insn_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        rq_rdy;
        logic        rdy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    vec_t        tbl[6];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          n_fire = 0;
    int          n_pop = 0;
    logic [31:0] model_pc = BASE;

    logic        s_rqv, s_v;
    logic [31:0] s_addr, s_pc, s_insn;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // One clock cycle: drive imem response, sample at negedge, update models.
    task automatic tick();
        logic fire, popv;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid_i = 1'b1;
            resp_insn_i  = insn_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            resp_valid_i = 1'b0;
            resp_insn_i  = '0;
        end
        @(negedge clk);
        s_rqv  = req_valid_o;
        s_addr = req_addr_o;
        s_v    = valid_o;
        s_pc   = pc_o;
        s_insn = insn_o;
        fire   = req_valid_o && req_ready_i;
        popv   = valid_o && ready_i;
        if (rst) begin
            chk("rst_req_valid", 32'(s_rqv), 32'd0);
            chk("rst_valid", 32'(s_v), 32'd0);
            chk("rst_pc", s_pc, 32'd0);
            chk("rst_insn", s_insn, 32'd0);
            pend.delete();
            exp_q.delete();
            model_pc = BASE;
            last_due = cyc;
        end else begin
            if (redirect_i) begin
                chk("redir_req_valid", 32'(s_rqv), 32'd0);
                chk("redir_valid", 32'(s_v), 32'd0);
            end
            if (fire) begin
                pend_t p;
                chk("req_addr", s_addr, model_pc);
                p.addr   = s_addr;
                p.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = p.due;
                pend.push_back(p);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                n_fire++;
            end
            if (popv) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %08h want no entry (cycle %0d)", s_pc, cyc);
                end else begin
                    chk("pop_pc", s_pc, exp_q[0]);
                    chk("pop_insn", s_insn, insn_of(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (redirect_i) begin
                exp_q.delete();
                model_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] want);
        int k;
        k = 0;
        tick();
        while (!s_v && k < 30) begin
            tick();
            k++;
        end
        chk({nm, "_valid"}, 32'(s_v), 32'd1);
        chk({nm, "_pc"}, s_pc, want);
        chk({nm, "_insn"}, s_insn, insn_of(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int k;
        tbl[0] = '{1'b1, 1'b1, 1'b1, BASE,          1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, BASE + 32'h4,  1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, BASE + 32'h8,  1'b1, BASE};
        tbl[3] = '{1'b1, 1'b1, 1'b1, BASE + 32'hC,  1'b1, BASE + 32'h4};
        tbl[4] = '{1'b1, 1'b1, 1'b1, BASE + 32'h10, 1'b1, BASE + 32'h8};
        tbl[5] = '{1'b1, 1'b1, 1'b1, BASE + 32'h14, 1'b1, BASE + 32'hC};

        rst           = 1'b1;
        req_ready_i   = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        resp_valid_i  = 1'b0;
        resp_insn_i   = '0;
        @(posedge clk);
        #1;

        // Streaming at L=1: first valid two cycles after first fire, no bubbles.
        lat = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_ready_i = tbl[i].rq_rdy;
            ready_i     = tbl[i].rdy;
            tick();
            chk("t1_req_valid", 32'(s_rqv), 32'(tbl[i].e_rqv));
            chk("t1_req_addr", s_addr, tbl[i].e_addr);
            chk("t1_valid", 32'(s_v), 32'(tbl[i].e_v));
            chk("t1_pc", s_pc, tbl[i].e_pc);
        end

        // Decode stalled: exactly FQ requests, then issue reopens after a pop.
        do_reset();
        lat = 1;
        req_ready_i = 1'b1;
        ready_i     = 1'b0;
        start = n_fire;
        for (int i = 0; i < 7; i++) tick();
        chk("t2_fires", 32'(n_fire - start), 32'd4);
        chk("t2_full_req_valid", 32'(s_rqv), 32'd0);
        ready_i = 1'b1;
        tick();
        chk("t2_head_pc", s_pc, BASE);
        chk("t2_pop_cycle_req_valid", 32'(s_rqv), 32'd0);
        tick();
        chk("t2_reopen_req_valid", 32'(s_rqv), 32'd1);
        chk("t2_reopen_addr", s_addr, BASE + 32'h10);
        for (int i = 0; i < 4; i++) tick();

        // Redirect with three requests in flight at L=3.
        do_reset();
        lat = 3;
        req_ready_i = 1'b1;
        ready_i     = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0100_0103;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("t3_new_req_valid", 32'(s_rqv), 32'd1);
        chk("t3_new_addr", s_addr, 32'h0100_0100);
        wait_valid("t3_first", 32'h0100_0100);

        // Redirect coinciding with a response, filled head present.
        do_reset();
        lat = 2;
        req_ready_i = 1'b1;
        ready_i     = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0200_0040;
        tick();
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        wait_valid("t4_first", 32'h0200_0040);

        // Random handshakes, latencies and occasional redirects.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req_ready_i   = 1'($urandom_range(0, 1));
            ready_i       = ($urandom_range(0, 3) != 0);
            lat           = int'($urandom_range(1, 3));
            redirect_i    = ($urandom_range(0, 49) == 0);
            redirect_pc_i = $urandom;
            tick();
        end
        redirect_i  = 1'b0;
        req_ready_i = 1'b0;
        ready_i     = 1'b1;
        k = 0;
        while ((exp_q.size() > 0 || pend.size() > 0) && k < 40) begin
            tick();
            k++;
        end
        chk("t5_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_progress", 32'(n_pop > 150), 32'd1);

        // Address wrap at the top of memory, then a mid-stream reset.
        lat           = 1;
        req_ready_i   = 1'b1;
        ready_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("t6_top_addr", s_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_wrap_addr", s_addr, 32'h0000_0000);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_rst_valid", 32'(s_v), 32'd0);
        chk("t6_post_rst_addr", s_addr, BASE);
        chk("t6_post_rst_req_valid", 32'(s_rqv), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
